// File: rtl/writeback_stage.sv
// ============================================================================
// Module   : writeback_stage
// Purpose  : RV64 write-back stage: RF/CSR write data, redirect, trap request.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module writeback_stage (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [63:0] WB_NPC,
  input  logic [63:0] WB_MEM_RESULT,
  input  logic [63:0] WB_ALU_RESULT,
  input  logic [31:0] WB_IR,
  input  logic        WB_PC_MUX,
  input  logic        WB_V,
  input  logic [63:0] WB_CSRFD,
  input  logic [63:0] WB_RFD,
  input  logic [4:0]  WB_DRID,
  input  logic        WB_ECALL,
  input  logic        FE_IAM,
  input  logic        FE_IAF,
  input  logic        FE_II,
  input  logic        MEM_LAM,
  input  logic        MEM_LAF,
  input  logic        MEM_SAM,
  input  logic        MEM_SAF,
  input  logic        TIMER,
  input  logic        EXTERNAL,
  input  logic        PRIVILEGE,
  output logic [63:0] WB_RF_DATA,
  output logic [63:0] WB_CSR_DATA,
  output logic [63:0] WB_BR_JMP_TARGET,
  output logic [4:0]  WB_DRID_OUT,
  output logic        WB_PC_MUX_OUT,
  output logic [63:0] WB_IR_OUT,
  output logic        WB_ST_REG,
  output logic        WB_ST_CSR,
  output logic [63:0] WB_CAUSE,
  output logic        WB_CS
);

  localparam logic [6:0] c_OP_IMM    = 7'b0010011;
  localparam logic [6:0] c_OP        = 7'b0110011;
  localparam logic [6:0] c_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] c_OP_32     = 7'b0111011;
  localparam logic [6:0] c_LUI       = 7'b0110111;
  localparam logic [6:0] c_AUIPC     = 7'b0010111;
  localparam logic [6:0] c_LOAD      = 7'b0000011;
  localparam logic [6:0] c_JAL       = 7'b1101111;
  localparam logic [6:0] c_JALR      = 7'b1100111;
  localparam logic [6:0] c_BRANCH    = 7'b1100011;
  localparam logic [6:0] c_SYSTEM    = 7'b1110011;

  localparam logic [63:0] c_INT_BIT  = 64'h8000_0000_0000_0000;

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [4:0]  w_rs1;
  logic [63:0] w_csr_src;

  logic [63:0] w_rf_data;
  logic [63:0] w_target;
  logic [63:0] w_csr_calc;
  logic        w_rd_write;
  logic        w_csr_write;
  logic        w_redirect;

  logic        w_trap;
  logic [63:0] w_cause;

  logic [63:0] rf_data_d,  rf_data_q;
  logic [63:0] csr_data_d, csr_data_q;
  logic [63:0] target_d,   target_q;
  logic [4:0]  drid_d,     drid_q;
  logic        pc_mux_d,   pc_mux_q;
  logic [63:0] ir_d,       ir_q;
  logic        st_reg_d,   st_reg_q;
  logic        st_csr_d,   st_csr_q;
  logic [63:0] cause_d,    cause_q;
  logic        cs_d,       cs_q;

  assign w_opcode  = WB_IR[6:0];
  assign w_funct3  = WB_IR[14:12];
  assign w_rs1     = WB_IR[19:15];
  // funct3[2] selects the zero-extended immediate form of the Zicsr ops
  assign w_csr_src = w_funct3[2] ? {59'b0, w_rs1} : WB_RFD;

  always_comb begin
    w_rf_data   = WB_ALU_RESULT;
    w_target    = WB_ALU_RESULT;
    w_csr_calc  = 64'b0;
    w_rd_write  = 1'b0;
    w_csr_write = 1'b0;
    w_redirect  = 1'b0;
    case (w_opcode)
      c_OP_IMM, c_OP, c_OP_IMM_32, c_OP_32, c_LUI, c_AUIPC: begin
        w_rd_write = 1'b1;
      end
      c_LOAD: begin
        w_rf_data  = WB_MEM_RESULT;
        w_rd_write = 1'b1;
      end
      c_JAL: begin
        w_rf_data  = WB_NPC;
        w_rd_write = 1'b1;
        w_redirect = 1'b1;
      end
      c_JALR: begin
        w_rf_data  = WB_NPC;
        w_rd_write = 1'b1;
        w_redirect = 1'b1;
        w_target   = {WB_ALU_RESULT[63:1], 1'b0};
      end
      c_BRANCH: begin
        w_redirect = WB_PC_MUX;
      end
      c_SYSTEM: begin
        if (w_funct3 != 3'b000) begin
          w_rf_data  = WB_CSRFD;
          w_rd_write = 1'b1;
          case (w_funct3[1:0])
            2'b01: begin
              w_csr_calc  = w_csr_src;
              w_csr_write = 1'b1;
            end
            2'b10: begin
              w_csr_calc  = WB_CSRFD | w_csr_src;
              w_csr_write = (w_rs1 != 5'd0);
            end
            2'b11: begin
              w_csr_calc  = WB_CSRFD & ~w_csr_src;
              w_csr_write = (w_rs1 != 5'd0);
            end
            default: begin
              w_csr_calc  = 64'b0;
              w_csr_write = 1'b0;
            end
          endcase
        end
      end
      default: begin
        w_rd_write = 1'b0;
      end
    endcase
  end

  // Interrupts outrank synchronous exceptions; only the winner is reported
  always_comb begin
    w_trap  = WB_V;
    w_cause = 64'd0;
    if (!WB_V) begin
      w_trap  = 1'b0;
    end else if (EXTERNAL) begin
      w_cause = c_INT_BIT | 64'd11;
    end else if (TIMER) begin
      w_cause = c_INT_BIT | 64'd7;
    end else if (FE_IAF) begin
      w_cause = 64'd1;
    end else if (FE_II) begin
      w_cause = 64'd2;
    end else if (FE_IAM) begin
      w_cause = 64'd0;
    end else if (WB_ECALL) begin
      w_cause = PRIVILEGE ? 64'd11 : 64'd8;
    end else if (MEM_SAM) begin
      w_cause = 64'd6;
    end else if (MEM_LAM) begin
      w_cause = 64'd4;
    end else if (MEM_SAF) begin
      w_cause = 64'd7;
    end else if (MEM_LAF) begin
      w_cause = 64'd5;
    end else begin
      w_trap  = 1'b0;
    end
  end

  always_comb begin
    rf_data_d  = w_rf_data;
    target_d   = w_target;
    drid_d     = WB_DRID;
    ir_d       = {32'b0, WB_IR};
    cause_d    = w_cause;
    cs_d       = w_trap;
    csr_data_d = w_trap ? (WB_NPC - 64'd4) : w_csr_calc;
    st_reg_d   = WB_V & w_rd_write & (WB_DRID != 5'd0) & ~w_trap;
    st_csr_d   = WB_V & w_csr_write & ~w_trap;
    pc_mux_d   = WB_V & w_redirect & ~w_trap;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rf_data_q  <= 64'b0;
      csr_data_q <= 64'b0;
      target_q   <= 64'b0;
      drid_q     <= 5'b0;
      pc_mux_q   <= 1'b0;
      ir_q       <= 64'b0;
      st_reg_q   <= 1'b0;
      st_csr_q   <= 1'b0;
      cause_q    <= 64'b0;
      cs_q       <= 1'b0;
    end else begin
      rf_data_q  <= rf_data_d;
      csr_data_q <= csr_data_d;
      target_q   <= target_d;
      drid_q     <= drid_d;
      pc_mux_q   <= pc_mux_d;
      ir_q       <= ir_d;
      st_reg_q   <= st_reg_d;
      st_csr_q   <= st_csr_d;
      cause_q    <= cause_d;
      cs_q       <= cs_d;
    end
  end

  assign WB_RF_DATA       = rf_data_q;
  assign WB_CSR_DATA      = csr_data_q;
  assign WB_BR_JMP_TARGET = target_q;
  assign WB_DRID_OUT      = drid_q;
  assign WB_PC_MUX_OUT    = pc_mux_q;
  assign WB_IR_OUT        = ir_q;
  assign WB_ST_REG        = st_reg_q;
  assign WB_ST_CSR        = st_csr_q;
  assign WB_CAUSE         = cause_q;
  assign WB_CS            = cs_q;

endmodule

`default_nettype wire

// File: tb/tb_writeback_stage.sv
// ============================================================================
// Module   : tb_writeback_stage
// Purpose  : Directed bench for writeback_stage with a reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_writeback_stage;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [63:0] WB_NPC, WB_MEM_RESULT, WB_ALU_RESULT, WB_CSRFD, WB_RFD;
  logic [31:0] WB_IR;
  logic        WB_PC_MUX, WB_V, WB_ECALL, PRIVILEGE;
  logic [4:0]  WB_DRID;
  logic        FE_IAM, FE_IAF, FE_II, MEM_LAM, MEM_LAF, MEM_SAM, MEM_SAF;
  logic        TIMER, EXTERNAL;

  logic [63:0] WB_RF_DATA, WB_CSR_DATA, WB_BR_JMP_TARGET, WB_IR_OUT, WB_CAUSE;
  logic [4:0]  WB_DRID_OUT;
  logic        WB_PC_MUX_OUT, WB_ST_REG, WB_ST_CSR, WB_CS;

  writeback_stage dut (
    .CLK(CLK), .RESET(RESET),
    .WB_NPC(WB_NPC), .WB_MEM_RESULT(WB_MEM_RESULT), .WB_ALU_RESULT(WB_ALU_RESULT),
    .WB_IR(WB_IR), .WB_PC_MUX(WB_PC_MUX), .WB_V(WB_V), .WB_CSRFD(WB_CSRFD),
    .WB_RFD(WB_RFD), .WB_DRID(WB_DRID), .WB_ECALL(WB_ECALL),
    .FE_IAM(FE_IAM), .FE_IAF(FE_IAF), .FE_II(FE_II),
    .MEM_LAM(MEM_LAM), .MEM_LAF(MEM_LAF), .MEM_SAM(MEM_SAM), .MEM_SAF(MEM_SAF),
    .TIMER(TIMER), .EXTERNAL(EXTERNAL), .PRIVILEGE(PRIVILEGE),
    .WB_RF_DATA(WB_RF_DATA), .WB_CSR_DATA(WB_CSR_DATA),
    .WB_BR_JMP_TARGET(WB_BR_JMP_TARGET), .WB_DRID_OUT(WB_DRID_OUT),
    .WB_PC_MUX_OUT(WB_PC_MUX_OUT), .WB_IR_OUT(WB_IR_OUT), .WB_ST_REG(WB_ST_REG),
    .WB_ST_CSR(WB_ST_CSR), .WB_CAUSE(WB_CAUSE), .WB_CS(WB_CS)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [63:0] rf, csr, tgt, ir, cause;
    logic [4:0]  drid;
    logic        pcm, streg, stcsr, cs;
  } out_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  bit   chk_en  = 1'b0;
  out_t exp_q   = '{default: '0};

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h, expected 0x%016h at %0t", name, act, req, $time);
    end
  endtask

  // Outputs derived from the instruction-class rules, then trap override
  function automatic out_t model();
    out_t o;
    logic [6:0] op;
    logic [2:0] f3;
    logic [4:0] z;
    logic [63:0] src;
    bit writes, csrw, redir, trap;
    logic [63:0] causes [10];
    bit pend [10];
    op = WB_IR[6:0]; f3 = WB_IR[14:12]; z = WB_IR[19:15];
    o.rf = WB_ALU_RESULT; o.tgt = WB_ALU_RESULT; o.csr = 64'd0;
    o.drid = WB_DRID; o.ir = {32'd0, WB_IR};
    writes = 0; csrw = 0; redir = 0;
    if (op inside {7'h13, 7'h33, 7'h1B, 7'h3B, 7'h37, 7'h17}) writes = 1;
    else if (op == 7'h03) begin o.rf = WB_MEM_RESULT; writes = 1; end
    else if (op == 7'h6F) begin o.rf = WB_NPC; writes = 1; redir = 1; end
    else if (op == 7'h67) begin o.rf = WB_NPC; writes = 1; redir = 1; o.tgt = WB_ALU_RESULT & ~64'd1; end
    else if (op == 7'h63) redir = WB_PC_MUX;
    else if (op == 7'h73 && f3 != 0) begin
      o.rf = WB_CSRFD; writes = 1;
      src = (f3 >= 4) ? 64'(z) : WB_RFD;
      if (f3 % 4 == 1) begin o.csr = src; csrw = 1; end
      else if (f3 % 4 == 2) begin o.csr = WB_CSRFD | src; csrw = (z != 0); end
      else if (f3 % 4 == 3) begin o.csr = WB_CSRFD & ~src; csrw = (z != 0); end
    end
    pend   = '{EXTERNAL, TIMER, FE_IAF, FE_II, FE_IAM, WB_ECALL, MEM_SAM, MEM_LAM, MEM_SAF, MEM_LAF};
    causes = '{64'h8000_0000_0000_000B, 64'h8000_0000_0000_0007, 1, 2, 0,
               PRIVILEGE ? 64'd11 : 64'd8, 6, 4, 7, 5};
    trap = 0; o.cause = 0;
    if (WB_V)
      for (int i = 0; i < 10; i++)
        if (!trap && pend[i]) begin trap = 1; o.cause = causes[i]; end
    o.cs    = trap;
    if (trap) o.csr = WB_NPC - 64'd4;
    o.streg = WB_V && !trap && writes && WB_DRID != 0;
    o.stcsr = WB_V && !trap && csrw;
    o.pcm   = WB_V && !trap && redir;
    return o;
  endfunction

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) exp_q = '{default: '0};
    else        exp_q = model();
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      cmp("rf_data",  WB_RF_DATA,       exp_q.rf);
      cmp("csr_data", WB_CSR_DATA,      exp_q.csr);
      cmp("target",   WB_BR_JMP_TARGET, exp_q.tgt);
      cmp("drid_out", 64'(WB_DRID_OUT), 64'(exp_q.drid));
      cmp("pc_mux",   64'(WB_PC_MUX_OUT), 64'(exp_q.pcm));
      cmp("ir_out",   WB_IR_OUT,        exp_q.ir);
      cmp("st_reg",   64'(WB_ST_REG),   64'(exp_q.streg));
      cmp("st_csr",   64'(WB_ST_CSR),   64'(exp_q.stcsr));
      cmp("cause",    WB_CAUSE,         exp_q.cause);
      cmp("cs",       64'(WB_CS),       64'(exp_q.cs));
    end
  end

  task automatic clear_in();
    WB_NPC = 64'h1000; WB_MEM_RESULT = 64'h0; WB_ALU_RESULT = 64'h0;
    WB_IR = 32'h0000_0013; WB_PC_MUX = 0; WB_V = 1; WB_CSRFD = 0; WB_RFD = 0;
    WB_DRID = 0; WB_ECALL = 0; PRIVILEGE = 0;
    FE_IAM = 0; FE_IAF = 0; FE_II = 0;
    MEM_LAM = 0; MEM_LAF = 0; MEM_SAM = 0; MEM_SAF = 0; TIMER = 0; EXTERNAL = 0;
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
    #1;
  endtask

  task automatic all_zero(input string tag);
    cmp({tag, "_rf"},    WB_RF_DATA, 64'd0);
    cmp({tag, "_csr"},   WB_CSR_DATA, 64'd0);
    cmp({tag, "_tgt"},   WB_BR_JMP_TARGET, 64'd0);
    cmp({tag, "_ir"},    WB_IR_OUT, 64'd0);
    cmp({tag, "_cause"}, WB_CAUSE, 64'd0);
    cmp({tag, "_flags"}, 64'({WB_DRID_OUT, WB_PC_MUX_OUT, WB_ST_REG, WB_ST_CSR, WB_CS}), 64'd0);
  endtask

  initial begin
    clear_in();
    WB_ALU_RESULT = 64'h1234; WB_DRID = 5'd7; WB_IR = 32'h0050_8093;
    #2 RESET = 1'b0;
    #1 all_zero("reset_noclk");
    repeat (2) @(posedge CLK);
    #1 all_zero("reset_clk");
    @(negedge CLK); #1;
    RESET = 1'b1;
    chk_en = 1'b1;

    // ADDI x1, x1, 5
    clear_in(); WB_IR = 32'h0050_8093; WB_ALU_RESULT = 64'd5; WB_DRID = 5'd1;
    step();
    cmp("addi_rf", WB_RF_DATA, 64'd5);
    cmp("addi_streg", 64'(WB_ST_REG), 64'd1);
    cmp("addi_ir", WB_IR_OUT, 64'h0000_0000_0050_8093);
    cmp("addi_strobes", 64'({WB_ST_CSR, WB_PC_MUX_OUT, WB_CS}), 64'd0);

    // JAL x1, 8
    clear_in(); WB_IR = 32'h0080_00EF; WB_NPC = 64'h104; WB_ALU_RESULT = 64'h108; WB_DRID = 5'd1;
    step();
    cmp("jal_rf", WB_RF_DATA, 64'h104);
    cmp("jal_pcm", 64'(WB_PC_MUX_OUT), 64'd1);
    cmp("jal_tgt", WB_BR_JMP_TARGET, 64'h108);

    // JALR clears target bit 0
    clear_in(); WB_IR = 32'h0000_80E7; WB_NPC = 64'h2A4; WB_ALU_RESULT = 64'h203; WB_DRID = 5'd1;
    step();
    cmp("jalr_tgt", WB_BR_JMP_TARGET, 64'h202);

    clear_in(); WB_IR = 32'h0000_B103; WB_MEM_RESULT = 64'hDEAD_BEEF_0000_0001; WB_DRID = 5'd2;
    step();
    cmp("load_rf", WB_RF_DATA, 64'hDEAD_BEEF_0000_0001);

    clear_in(); WB_IR = 32'h0020_8463; WB_PC_MUX = 1; WB_ALU_RESULT = 64'h300; WB_DRID = 5'd8;
    step();
    cmp("br_taken_pcm", 64'(WB_PC_MUX_OUT), 64'd1);
    cmp("br_streg", 64'(WB_ST_REG), 64'd0);
    WB_PC_MUX = 0;
    step();

    clear_in(); WB_IR = 32'h0020_B023; WB_ALU_RESULT = 64'h55; WB_DRID = 5'd0;
    step();

    // CSRRS x2, mstatus, x0 : read only
    clear_in(); WB_IR = 32'h3000_2173; WB_CSRFD = 64'hAA; WB_DRID = 5'd2; WB_RFD = 64'hFFFF;
    step();
    cmp("csrrs0_rf", WB_RF_DATA, 64'hAA);
    cmp("csrrs0_stcsr", 64'(WB_ST_CSR), 64'd0);

    // CSRRC x3, mstatus, x1
    clear_in(); WB_IR = 32'h3000_B1F3; WB_RFD = 64'h0F; WB_CSRFD = 64'hFF; WB_DRID = 5'd3;
    step();
    cmp("csrrc_data", WB_CSR_DATA, 64'hF0);
    cmp("csrrc_stcsr", 64'(WB_ST_CSR), 64'd1);

    // CSRRWI x4, mstatus, 5
    clear_in(); WB_IR = 32'h3002_D273; WB_CSRFD = 64'h77; WB_RFD = 64'h99; WB_DRID = 5'd4;
    step();
    cmp("csrrwi_data", WB_CSR_DATA, 64'd5);

    // CSRRSI with nonzero zimm
    clear_in(); WB_IR = 32'h3001_E273; WB_CSRFD = 64'h10; WB_DRID = 5'd4;
    step();

    // ECALL and interrupts layered on top
    clear_in(); WB_IR = 32'h0000_0073; WB_ECALL = 1; WB_NPC = 64'h204; WB_DRID = 5'd1;
    step();
    cmp("ecall_cs", 64'(WB_CS), 64'd1);
    cmp("ecall_cause", WB_CAUSE, 64'd8);
    cmp("ecall_mepc", WB_CSR_DATA, 64'h200);
    cmp("ecall_streg", 64'(WB_ST_REG), 64'd0);
    TIMER = 1;
    step();
    cmp("timer_cause", WB_CAUSE, 64'h8000_0000_0000_0007);
    EXTERNAL = 1;
    step();
    cmp("ext_cause", WB_CAUSE, 64'h8000_0000_0000_000B);
    TIMER = 0; EXTERNAL = 0; PRIVILEGE = 1;
    step();
    cmp("ecall_m_cause", WB_CAUSE, 64'd11);

    // Exception priority pairs on a JAL, which would otherwise redirect and write
    clear_in(); WB_IR = 32'h0080_00EF; WB_DRID = 5'd1; WB_NPC = 64'h504;
    FE_IAF = 1; FE_II = 1; step();
    cmp("iaf_cause", WB_CAUSE, 64'd1);
    cmp("trap_pcm", 64'(WB_PC_MUX_OUT), 64'd0);
    FE_IAF = 0; step();
    FE_II = 0; FE_IAM = 1; WB_ECALL = 1; step();
    cmp("iam_cs", 64'(WB_CS), 64'd1);
    cmp("iam_cause", WB_CAUSE, 64'd0);
    FE_IAM = 0; WB_ECALL = 0; MEM_SAM = 1; MEM_LAM = 1; step();
    cmp("sam_cause", WB_CAUSE, 64'd6);
    MEM_SAM = 0; step();
    MEM_LAM = 0; MEM_SAF = 1; MEM_LAF = 1; step();
    cmp("saf_cause", WB_CAUSE, 64'd7);
    MEM_SAF = 0; step();
    cmp("laf_cause", WB_CAUSE, 64'd5);

    // Invalid instruction ignores exceptions
    clear_in(); WB_IR = 32'h0050_8093; WB_V = 0; FE_II = 1; WB_DRID = 5'd1; EXTERNAL = 1;
    step();
    cmp("inv_cs", 64'(WB_CS), 64'd0);
    cmp("inv_strobes", 64'({WB_ST_REG, WB_ST_CSR, WB_PC_MUX_OUT}), 64'd0);

    clear_in(); WB_IR = 32'h0050_0013; WB_ALU_RESULT = 64'd5; WB_DRID = 5'd0;
    step();
    cmp("x0_streg", 64'(WB_ST_REG), 64'd0);

    // Reset asserted between edges clears outputs at once
    clear_in(); WB_IR = 32'h0080_00EF; WB_NPC = 64'h404; WB_ALU_RESULT = 64'h408; WB_DRID = 5'd9;
    step();
    #2 RESET = 1'b0;
    #1 all_zero("async_rst");
    @(negedge CLK); #1;
    RESET = 1'b1;
    step();
    step();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
